invader_formation: RTL and testbench

Formation motion and state controller for the 10×6 invader grid. It sits directly upstream of the VGA renderer and supplies three things:
- the grid origin (`form_x`, `form_y`),
- the per-invader alive mask,
- the march direction.

The renderer derives each square as `origin + col*COL_PITCH`, `origin + row*ROW_PITCH`. State changes only on `frame_tick`, issued by the timing generator at the start of vertical blanking, so the renderer always sees stable values during the visible area. Kill requests from the collision logic clear alive bits through a valid/ready handshake.

---
 rtl/invader_pkg.sv | 22 ++
 rtl/formation_alive_reduce.sv | 29 ++
 rtl/invader_formation.sv | 141 ++++++++++++++
 tb/tb_invader_formation.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invader_pkg.sv
// Geometry and state definitions for the invader formation, shared with the renderer.
package invader_pkg;

   localparam int unsigned COLS         = 10;
   localparam int unsigned ROWS         = 6;
   localparam int unsigned N_INV        = COLS * ROWS;
   localparam int unsigned H_DISPLAY    = 640;
   localparam int unsigned V_DISPLAY    = 480;
   localparam int unsigned X0           = 40;
   localparam int unsigned Y0           = 100;
   localparam int unsigned COL_PITCH    = 60;
   localparam int unsigned ROW_PITCH    = 50;
   localparam int unsigned INV_W        = 15;
   localparam int unsigned INV_H        = 10;
   localparam int unsigned STEP_X       = 4;
   localparam int unsigned STEP_Y       = 10;
   localparam int unsigned BOTTOM_LIMIT = 440;
   localparam int unsigned WAVE_MAX     = 15;

   typedef enum logic [1:0] {WAIT, SCAN, MOVE} form_state_e;

endpackage

// File: rtl/formation_alive_reduce.sv
// Reduces the alive mask to per-column / per-row occupancy and the lowest occupied row.
module formation_alive_reduce
   import invader_pkg::*;
(
   input  logic [N_INV-1:0] alive,
   output logic [COLS-1:0]  col_alive_c,
   output logic [ROWS-1:0]  row_alive_c,
   output logic [2:0]       lowest_row_c
);

   logic [2:0] lr_chain [ROWS+1];

   for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [ROWS-1:0] col_bits;
      for (genvar r = 0; r < ROWS; r++) begin : g_bit
         assign col_bits[r] = alive[r*COLS + c];
      end
      assign col_alive_c[c] = |col_bits;
   end

   // Later (lower on screen) occupied rows override earlier ones.
   assign lr_chain[0] = '0;
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign row_alive_c[r]  = |alive[r*COLS +: COLS];
      assign lr_chain[r+1]   = row_alive_c[r] ? 3'(r) : lr_chain[r];
   end
   assign lowest_row_c = lr_chain[ROWS];

endmodule

// File: rtl/invader_formation.sv
// Formation motion/state controller: marches the 10x6 grid once per period of frame ticks
// and clears invaders on kill requests.
module invader_formation
   import invader_pkg::*;
(
   input  logic             CLK,
   input  logic             SW1,
   input  logic             frame_tick,
   input  logic             kill_valid,
   input  logic [5:0]       kill_index,
   output logic             kill_ready,
   output logic [9:0]       form_x,
   output logic [9:0]       form_y,
   output logic [N_INV-1:0] alive,
   output logic             dir,
   output logic             step_pulse,
   output logic [3:0]       wave,
   output logic             game_over
);

   form_state_e state;
   logic [5:0]  alive_count;
   logic [3:0]  frame_cnt;
   logic        scan_pending;
   logic [3:0]  scan_idx;
   logic [3:0]  leftmost;
   logic [3:0]  rightmost;
   logic        found;

   logic [COLS-1:0] col_alive_c;
   logic [ROWS-1:0] row_alive_c;
   logic [2:0]      lowest_row_c;
   logic            kill_hit_c;
   logic [4:0]      period_c;
   logic            step_due_c;
   logic            right_hit_c;
   logic            left_hit_c;
   logic            edge_hit_c;
   logic [9:0]      new_y_c;
   logic            bottom_c;

   formation_alive_reduce u_reduce (
      .alive        (alive),
      .col_alive_c  (col_alive_c),
      .row_alive_c  (row_alive_c),
      .lowest_row_c (lowest_row_c)
   );

   assign kill_hit_c  = kill_valid && kill_ready && (kill_index < 6'(N_INV)) && alive[kill_index];
   assign period_c    = 5'(alive_count[5:2]) + 5'd1;
   assign step_due_c  = !((5'(frame_cnt) + 5'd1) < period_c);

   // Edge tests and bottom test on 11-bit intermediates.
   assign right_hit_c = !dir && ((11'(form_x) + 11'(rightmost) * 11'(COL_PITCH)
                                  + 11'(INV_W + STEP_X)) > 11'(H_DISPLAY));
   assign left_hit_c  = dir && ((11'(form_x) + 11'(leftmost) * 11'(COL_PITCH)) < 11'(STEP_X));
   assign edge_hit_c  = right_hit_c || left_hit_c;
   assign new_y_c     = edge_hit_c ? form_y + 10'(STEP_Y) : form_y;
   assign bottom_c    = (|row_alive_c) &&
                        ((11'(new_y_c) + 11'(lowest_row_c) * 11'(ROW_PITCH) + 11'(INV_H))
                         > 11'(BOTTOM_LIMIT));

   always_ff @(posedge CLK or posedge SW1) begin
      if (SW1) begin
         state        <= WAIT;
         form_x       <= 10'(X0);
         form_y       <= 10'(Y0);
         alive        <= '1;
         dir          <= 1'b0;
         wave         <= '0;
         game_over    <= 1'b0;
         step_pulse   <= 1'b0;
         kill_ready   <= 1'b1;
         alive_count  <= 6'(N_INV);
         frame_cnt    <= '0;
         scan_pending <= 1'b0;
         scan_idx     <= '0;
         leftmost     <= '0;
         rightmost    <= '0;
         found        <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         case (state)
            WAIT: begin
               if (kill_hit_c) begin
                  alive[kill_index] <= 1'b0;
                  alive_count       <= alive_count - 6'd1;
               end
               // The tick decision is taken on the pre-kill count; the scan starts next cycle.
               if (scan_pending) begin
                  scan_pending <= 1'b0;
                  state        <= SCAN;
                  kill_ready   <= 1'b0;
                  scan_idx     <= '0;
                  found        <= 1'b0;
                  leftmost     <= '0;
                  rightmost    <= '0;
               end else if (frame_tick && !game_over) begin
                  if (alive_count == '0) begin
                     form_x      <= 10'(X0);
                     form_y      <= 10'(Y0);
                     alive       <= '1;
                     alive_count <= 6'(N_INV);
                     dir         <= 1'b0;
                     frame_cnt   <= '0;
                     if (wave != 4'(WAVE_MAX)) wave <= wave + 4'd1;
                  end else if (!step_due_c) begin
                     frame_cnt <= frame_cnt + 4'd1;
                  end else begin
                     frame_cnt    <= '0;
                     scan_pending <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (col_alive_c[scan_idx]) begin
                  if (!found) leftmost <= scan_idx;
                  found     <= 1'b1;
                  rightmost <= scan_idx;
               end
               if (scan_idx == 4'(COLS - 1)) state <= MOVE;
               else scan_idx <= scan_idx + 4'd1;
            end
            MOVE: begin
               if (edge_hit_c) begin
                  form_y <= new_y_c;
                  dir    <= ~dir;
               end else begin
                  form_x <= dir ? form_x - 10'(STEP_X) : form_x + 10'(STEP_X);
               end
               if (bottom_c) game_over <= 1'b1;
               step_pulse <= 1'b1;
               kill_ready <= 1'b1;
               state      <= WAIT;
            end
            default: state <= WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_invader_formation.sv
// Directed + randomized bench for invader_formation against a transaction-level model.
module tb_invader_formation;
   import invader_pkg::*;

   logic        CLK = 1'b0;
   logic        SW1;
   logic        frame_tick;
   logic        kill_valid;
   logic [5:0]  kill_index;
   logic        kill_ready;
   logic [9:0]  form_x;
   logic [9:0]  form_y;
   logic [59:0] alive;
   logic        dir;
   logic        step_pulse;
   logic [3:0]  wave;
   logic        game_over;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_alive [60];
   int m_count, m_x, m_y, m_dir, m_fc, m_wave, m_go;
   int kq[$];

   invader_formation dut (
      .CLK        (CLK),
      .SW1        (SW1),
      .frame_tick (frame_tick),
      .kill_valid (kill_valid),
      .kill_index (kill_index),
      .kill_ready (kill_ready),
      .form_x     (form_x),
      .form_y     (form_y),
      .alive      (alive),
      .dir        (dir),
      .step_pulse (step_pulse),
      .wave       (wave),
      .game_over  (game_over)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_fill();
      for (int i = 0; i < 60; i++) m_alive[i] = 1'b1;
      m_count = 60; m_x = 40; m_y = 100; m_dir = 0; m_fc = 0;
   endfunction

   function automatic void model_reset();
      model_fill();
      m_wave = 0; m_go = 0;
   endfunction

   function automatic logic [63:0] model_vec();
      logic [63:0] v = '0;
      for (int i = 0; i < 60; i++) if (m_alive[i]) v = v | (64'd1 << i);
      return v;
   endfunction

   function automatic void model_kill(input int idx);
      if (idx < 60 && m_alive[idx]) begin
         m_alive[idx] = 1'b0;
         m_count--;
      end
   endfunction

   // One frame tick at transaction level; returns 1 when the formation steps.
   function automatic bit model_tick(input int cnt);
      int lm = -1, rm = -1, lr = -1;
      bit hit;
      if (m_go != 0) return 1'b0;
      if (cnt == 0) begin
         model_fill();
         if (m_wave < 15) m_wave++;
         return 1'b0;
      end
      if (m_fc + 1 < cnt / 4 + 1) begin
         m_fc++;
         return 1'b0;
      end
      m_fc = 0;
      for (int c = 0; c < 10; c++)
         for (int r = 0; r < 6; r++)
            if (m_alive[r*10 + c]) begin
               if (lm < 0) lm = c;
               rm = c;
               if (r > lr) lr = r;
            end
      if (lm < 0) begin lm = 0; rm = 0; lr = 0; end
      hit = (m_dir == 0 && m_x + rm*60 + 15 + 4 > 640) || (m_dir == 1 && m_x + lm*60 < 4);
      if (hit) begin
         m_y += 10;
         m_dir = 1 - m_dir;
      end else begin
         m_x += (m_dir != 0) ? -4 : 4;
      end
      if (m_y + lr*50 + 10 > 440) m_go = 1;
      return 1'b1;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "/form_x"},    64'(form_x),    64'(m_x));
      chk({tag, "/form_y"},    64'(form_y),    64'(m_y));
      chk({tag, "/alive"},     64'(alive),     model_vec());
      chk({tag, "/dir"},       64'(dir),       64'(m_dir));
      chk({tag, "/wave"},      64'(wave),      64'(m_wave));
      chk({tag, "/game_over"}, 64'(game_over), 64'(m_go));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      SW1 = 1'b1; frame_tick = 1'b0; kill_valid = 1'b0; kill_index = '0;
      repeat (2) @(negedge CLK);
      SW1 = 1'b0;
      model_reset();
      @(negedge CLK);
      check_all("reset");
      chk("reset/step_pulse", 64'(step_pulse), 64'd0);
      chk("reset/kill_ready", 64'(kill_ready), 64'd1);
   endtask

   task automatic do_kill(input int idx);
      @(negedge CLK);
      chk("kill/ready_idle", 64'(kill_ready), 64'd1);
      kill_valid = 1'b1;
      kill_index = 6'(idx);
      @(negedge CLK);
      kill_valid = 1'b0;
      model_kill(idx);
      chk("kill/alive", 64'(alive), model_vec());
   endtask

   task automatic shuffle_kq();
      for (int i = kq.size() - 1; i > 0; i--) begin
         int j = int'($urandom_range(0, i));
         int t = kq[i];
         kq[i] = kq[j];
         kq[j] = t;
      end
   endtask

   task automatic kill_kq();
      shuffle_kq();
      foreach (kq[i]) begin
         do_kill(kq[i]);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
   endtask

   // Tick with optional simultaneous kill, or a kill raised during the scan and held.
   task automatic do_tick(input bit sim_kill, input int sim_idx, input bit mid_kill, input int mid_idx);
      int pre, lowcnt = 0, pulses = 0, pulse_at = -1, accept_k = -1, old_x;
      bit exp_step, pend = 1'b0;
      logic [9:0] x_at11 = '0;
      @(negedge CLK);
      old_x = m_x;
      frame_tick = 1'b1;
      if (sim_kill) begin kill_valid = 1'b1; kill_index = 6'(sim_idx); end
      pre = m_count;
      if (sim_kill) model_kill(sim_idx);
      exp_step = model_tick(pre);
      for (int k = 0; k < 14; k++) begin
         @(negedge CLK);
         if (k == 0) begin frame_tick = 1'b0; if (sim_kill) kill_valid = 1'b0; end
         if (k >= 1 && !kill_ready) lowcnt++;
         if (step_pulse) begin pulses++; pulse_at = k; end
         if (k == 11) x_at11 = form_x;
         if (mid_kill) begin
            if (pend) begin kill_valid = 1'b0; pend = 1'b0; end
            else if (kill_valid && kill_ready) begin pend = 1'b1; accept_k = k; end
            if (k == 3) begin kill_valid = 1'b1; kill_index = 6'(mid_idx); end
         end
      end
      if (mid_kill) model_kill(mid_idx);
      chk("tick/pulse_count", 64'(pulses), 64'(exp_step));
      if (exp_step) begin
         chk("tick/pulse_latency", 64'(pulse_at), 64'd12);
         chk("tick/ready_low_cycles", 64'(lowcnt), 64'd11);
         chk("tick/x_before_update", 64'(x_at11), 64'(old_x));
         if (mid_kill) chk("tick/held_kill_ready_k", 64'(accept_k), 64'd12);
      end else begin
         chk("tick/ready_low_cycles", 64'(lowcnt), 64'd0);
      end
      check_all("tick");
   endtask

   initial begin
      int n, e;
      SW1 = 1'b1; frame_tick = 1'b0; kill_valid = 1'b0; kill_index = '0;
      do_reset();

      // First step after 16 ticks, then march to the right edge and drop
      for (int i = 1; i <= 16; i++) begin
         do_tick(0, 0, 0, 0);
         if (i == 15) chk("tick15/form_x", 64'(form_x), 64'd40);
      end
      chk("tick16/form_x", 64'(form_x), 64'd44);
      for (int i = 0; i < 16*11; i++) do_tick(0, 0, 0, 0);
      chk("step12/form_x", 64'(form_x), 64'd84);
      chk("step12/form_y", 64'(form_y), 64'd110);
      chk("step12/dir", 64'(dir), 64'd1);

      // Out-of-range and repeat kills
      do_kill(63);
      do_kill(0);
      do_kill(0);

      // Column 9 destroyed: right edge moves in
      do_reset();
      kq = {};
      for (int r = 0; r < 6; r++) kq.push_back(r*10 + 9);
      kill_kq();
      n = 0;
      while (m_y == 100 && n < 600) begin do_tick(0, 0, 0, 0); n++; end
      chk("col9/bounded", 64'(n < 600), 64'd1);
      chk("col9/drop_x", 64'(form_x), 64'd144);
      chk("col9/drop_y", 64'(form_y), 64'd110);

      // Kill requested mid-scan is held until ready returns
      n = 0;
      while (m_fc + 1 < m_count/4 + 1 && n < 20) begin do_tick(0, 0, 0, 0); n++; end
      do_tick(0, 0, 1, int'($urandom_range(1, 8)) + 10*int'($urandom_range(0, 5)));

      // Simultaneous kill and tick uses the pre-kill count; then march to game over
      do_reset();
      e = int'($urandom_range(1, 49));
      kq = {};
      for (int i = 0; i < 60; i++)
         if (i != 0 && i != 50 && i != 59 && i != e) kq.push_back(i);
      kill_kq();
      do_kill(60 + int'($urandom_range(0, 3)));
      do_tick(1, e, 0, 0);
      n = 0;
      while (m_go == 0 && n < 500) begin do_tick(0, 0, 0, 0); n++; end
      chk("gameover/bounded", 64'(n < 500), 64'd1);
      chk("gameover/flag", 64'(game_over), 64'd1);
      chk("gameover/form_y", 64'(form_y), 64'd190);
      for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 0);
      kq = {0, 50, 59};
      kill_kq();
      do_tick(0, 0, 0, 0);
      chk("gameover/no_reload_wave", 64'(wave), 64'd0);

      // Asynchronous reset in the middle of a scan
      do_reset();
      for (int i = 0; i < 31; i++) do_tick(0, 0, 0, 0);
      @(negedge CLK); frame_tick = 1'b1;
      @(negedge CLK); frame_tick = 1'b0;
      repeat (4) @(negedge CLK);
      chk("midscan/kill_ready", 64'(kill_ready), 64'd0);
      #2 SW1 = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      chk("async_reset/kill_ready", 64'(kill_ready), 64'd1);
      chk("async_reset/step_pulse", 64'(step_pulse), 64'd0);
      @(negedge CLK); SW1 = 1'b0;
      repeat (12) @(negedge CLK);
      check_all("after_reset_idle");

      // Wave clears and reloads
      for (int w = 1; w <= 3; w++) begin
         kq = {};
         for (int i = 0; i < 60; i++) kq.push_back(i);
         kill_kq();
         do_tick(0, 0, 0, 0);
         chk("wave/count", 64'(wave), 64'(w));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
